// File: rtl/rikv_bus_pkg.sv
// Shared types and helpers for the rikv iBus/dBus arbiter slice.
package rikv_bus_pkg;

  // Which requester a command or outstanding read belongs to
  typedef enum logic {
    SRC_IBUS = 1'b0,
    SRC_DBUS = 1'b1
  } src_e;

  // Arbiter states: idle, or holding a granted command for one source
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  // dBus access size encodings
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] byteMask(input logic [1:0] size, input logic [1:0] addrLow);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001 << addrLow;
      SIZE_H:  mask = 4'b0011 << {addrLow[1], 1'b0};
      default: mask = MASK_ALL;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rikv_src_fifo.sv
// In-order FIFO of source tags, one entry per outstanding memory read.
module rikv_src_fifo
  import rikv_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  src_e             pushSrc,
  input  logic             pop,
  output src_e             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  src_e             slots [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             wrEn;
  logic             rdEn;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Status flags and guarded enables so the FIFO never over/underflows
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    wrEn  = push && !full;
    rdEn  = pop && !empty;
    head  = slots[rdPtr];
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= nextPtr(wrPtr);
      if (rdEn) rdPtr <= nextPtr(rdPtr);
      case ({wrEn, rdEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset; entries are only read once written
  always_ff @(posedge clock) begin
    if (wrEn) slots[wrPtr] <= pushSrc;
  end

endmodule

// File: rtl/rikv_bus_arbiter.sv
// Merges rikv iBus and dBus onto one memory port with dBus priority,
// a starvation guard for iBus, and in-order read response routing.
module rikv_bus_arbiter
  import rikv_bus_pkg::*;
#(
  parameter int PENDING_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ibus_cmd_valid,
  output logic        ibus_cmd_ready,
  input  logic [31:0] ibus_cmd_payload_pc,
  output logic        ibus_rsp_ready,
  output logic [31:0] ibus_rsp_inst,
  input  logic        dbus_cmd_valid,
  output logic        dbus_cmd_ready,
  input  logic        dbus_cmd_payload_wr,
  input  logic [31:0] dbus_cmd_payload_address,
  input  logic [31:0] dbus_cmd_payload_data,
  input  logic [1:0]  dbus_cmd_payload_size,
  output logic        dbus_rsp_ready,
  output logic [31:0] dbus_rsp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_wr,
  output logic [31:0] mem_cmd_address,
  output logic [31:0] mem_cmd_data,
  output logic [3:0]  mem_cmd_mask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rsp_unexpected
);

  localparam int CNT_W    = $clog2(PENDING_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state;
  logic [STARVE_W-1:0] starveCnt;
  logic [CNT_W-1:0]    pendingCount;
  logic                fifoFull;
  logic                fifoEmpty;
  src_e                fifoHead;
  src_e                pushSrc;
  logic                readRoom;
  logic                ibusEligible;
  logic                dbusEligible;
  logic                starved;
  logic                grantIbus;
  logic                grantDbus;
  logic                pushRead;
  logic                popRead;
  logic                unusedBits;

  // The low pc bits are ignored because fetches are always word-wide
  assign unusedBits = ^{ibus_cmd_payload_pc[1:0], fifoFull};

  // Arbitration is only live in IDLE and out of reset; reads need FIFO room
  always_comb begin
    readRoom     = (pendingCount < CNT_W'(PENDING_DEPTH));
    ibusEligible = ibus_cmd_valid && readRoom;
    dbusEligible = dbus_cmd_valid && (dbus_cmd_payload_wr || readRoom);
    starved      = (starveCnt == STARVE_W'(STARVE_LIMIT));
    grantIbus    = !reset && (state == ST_IDLE) && ibusEligible && (starved || !dbusEligible);
    grantDbus    = !reset && (state == ST_IDLE) && dbusEligible && !(ibusEligible && starved);
    ibus_cmd_ready = grantIbus;
    dbus_cmd_ready = grantDbus;
  end

  // Read bookkeeping and combinational routing of responses to the issuing source
  always_comb begin
    pushSrc        = (state == ST_GRANT_D) ? SRC_DBUS : SRC_IBUS;
    pushRead       = mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr;
    popRead        = mem_rsp_valid && !fifoEmpty && !reset;
    ibus_rsp_ready = popRead && (fifoHead == SRC_IBUS);
    dbus_rsp_ready = popRead && (fifoHead == SRC_DBUS);
    ibus_rsp_inst  = ibus_rsp_ready ? mem_rsp_data : '0;
    dbus_rsp_data  = dbus_rsp_ready ? mem_rsp_data : '0;
  end

  // Command FSM: capture the winner's payload, then hold it until memory accepts
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      mem_cmd_valid   <= 1'b0;
      mem_cmd_wr      <= 1'b0;
      mem_cmd_address <= '0;
      mem_cmd_data    <= '0;
      mem_cmd_mask    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grantIbus) begin
            state           <= ST_GRANT_I;
            mem_cmd_valid   <= 1'b1;
            mem_cmd_wr      <= 1'b0;
            mem_cmd_address <= {ibus_cmd_payload_pc[31:2], 2'b00};
            mem_cmd_data    <= '0;
            mem_cmd_mask    <= MASK_ALL;
          end else if (grantDbus) begin
            state           <= ST_GRANT_D;
            mem_cmd_valid   <= 1'b1;
            mem_cmd_wr      <= dbus_cmd_payload_wr;
            mem_cmd_address <= {dbus_cmd_payload_address[31:2], 2'b00};
            mem_cmd_data    <= dbus_cmd_payload_data;
            mem_cmd_mask    <= byteMask(dbus_cmd_payload_size, dbus_cmd_payload_address[1:0]);
          end
        end
        ST_GRANT_I, ST_GRANT_D: begin
          if (mem_cmd_ready) begin
            state         <= ST_IDLE;
            mem_cmd_valid <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          mem_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count consecutive dBus wins while iBus waits; any iBus grant or idle iBus clears it
  always_ff @(posedge clock) begin
    if (reset || !ibus_cmd_valid || grantIbus) begin
      starveCnt <= '0;
    end else if (grantDbus && !starved) begin
      starveCnt <= starveCnt + STARVE_W'(1);
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_unexpected <= 1'b0;
    end else if (mem_rsp_valid && fifoEmpty) begin
      rsp_unexpected <= 1'b1;
    end
  end

  rikv_src_fifo #(
    .DEPTH(PENDING_DEPTH)
  ) srcFifo (
    .clock   (clock),
    .reset   (reset),
    .push    (pushRead),
    .pushSrc (pushSrc),
    .pop     (popRead),
    .head    (fifoHead),
    .count   (pendingCount),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

endmodule

// File: tb/tb_rikv_bus_arbiter.sv
// Scenario bench for rikv_bus_arbiter plus a randomized run against a queue-based model.
module tb_rikv_bus_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clock;
  logic        reset;
  logic        ibus_cmd_valid;
  logic        ibus_cmd_ready;
  logic [31:0] ibus_cmd_payload_pc;
  logic        ibus_rsp_ready;
  logic [31:0] ibus_rsp_inst;
  logic        dbus_cmd_valid;
  logic        dbus_cmd_ready;
  logic        dbus_cmd_payload_wr;
  logic [31:0] dbus_cmd_payload_address;
  logic [31:0] dbus_cmd_payload_data;
  logic [1:0]  dbus_cmd_payload_size;
  logic        dbus_rsp_ready;
  logic [31:0] dbus_rsp_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_wr;
  logic [31:0] mem_cmd_address;
  logic [31:0] mem_cmd_data;
  logic [3:0]  mem_cmd_mask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_unexpected;

  int checks;
  int errors;

  rikv_bus_arbiter #(
    .PENDING_DEPTH(DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .ibus_cmd_valid           (ibus_cmd_valid),
    .ibus_cmd_ready           (ibus_cmd_ready),
    .ibus_cmd_payload_pc      (ibus_cmd_payload_pc),
    .ibus_rsp_ready           (ibus_rsp_ready),
    .ibus_rsp_inst            (ibus_rsp_inst),
    .dbus_cmd_valid           (dbus_cmd_valid),
    .dbus_cmd_ready           (dbus_cmd_ready),
    .dbus_cmd_payload_wr      (dbus_cmd_payload_wr),
    .dbus_cmd_payload_address (dbus_cmd_payload_address),
    .dbus_cmd_payload_data    (dbus_cmd_payload_data),
    .dbus_cmd_payload_size    (dbus_cmd_payload_size),
    .dbus_rsp_ready           (dbus_rsp_ready),
    .dbus_rsp_data            (dbus_rsp_data),
    .mem_cmd_valid            (mem_cmd_valid),
    .mem_cmd_ready            (mem_cmd_ready),
    .mem_cmd_wr               (mem_cmd_wr),
    .mem_cmd_address          (mem_cmd_address),
    .mem_cmd_data             (mem_cmd_data),
    .mem_cmd_mask             (mem_cmd_mask),
    .mem_rsp_valid            (mem_rsp_valid),
    .mem_rsp_data             (mem_rsp_data),
    .rsp_unexpected           (rsp_unexpected)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic dv, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                               input logic mready, input logic rvalid, input logic [31:0] rdata);
    ibus_cmd_valid           = iv;
    ibus_cmd_payload_pc      = pc;
    dbus_cmd_valid           = dv;
    dbus_cmd_payload_wr      = wr;
    dbus_cmd_payload_address = addr;
    dbus_cmd_payload_data    = data;
    dbus_cmd_payload_size    = size;
    mem_cmd_ready            = mready;
    mem_rsp_valid            = rvalid;
    mem_rsp_data             = rdata;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic endCycle();
    @(posedge clock);
    #1;
  endtask

  // Byte enables from access width and offset, aligned down to the width
  function automatic logic [3:0] expectedMask(input logic [1:0] size, input logic [31:0] addr);
    int bytes;
    int offset;
    bytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    offset = (bytes == 4) ? 0 : (int'(addr % 4) / bytes) * bytes;
    return 4'(((1 << bytes) - 1) << offset);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b1, 1'b1, 32'hDEAD);
    endCycle();
    endCycle();
    @(negedge clock);
    checks++; if (ibus_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_iready got %b expected 0", ibus_cmd_ready); end
    checks++; if (dbus_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_dready got %b expected 0", dbus_cmd_ready); end
    checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mvalid got %b expected 0", mem_cmd_valid); end
    checks++; if ({ibus_rsp_ready, dbus_rsp_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp got %b expected 00", {ibus_rsp_ready, dbus_rsp_ready}); end
    checks++; if (rsp_unexpected !== 1'b0) begin errors++; $display("[TB] FAIL reset_unexp got %b expected 0", rsp_unexpected); end
    checks++; if ({mem_cmd_wr, mem_cmd_address, mem_cmd_data, mem_cmd_mask} !== 69'h0) begin errors++; $display("[TB] FAIL reset_payload got %h %h %h %h expected zeros", mem_cmd_wr, mem_cmd_address, mem_cmd_data, mem_cmd_mask); end
    endCycle();
    reset = 1'b0;
    idleInputs();
  endtask

  task automatic test_ifetch();
    idleInputs();
    ibus_cmd_valid = 1'b1; ibus_cmd_payload_pc = 32'h100;
    @(negedge clock);
    checks++; if ({ibus_cmd_ready, dbus_cmd_ready, mem_cmd_valid} !== 3'b100) begin errors++; $display("[TB] FAIL fetch_grant got %b expected 100", {ibus_cmd_ready, dbus_cmd_ready, mem_cmd_valid}); end
    endCycle();
    idleInputs();
    mem_cmd_ready = 1'b1;
    @(negedge clock);
    checks++; if (mem_cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mvalid got %b expected 1", mem_cmd_valid); end
    checks++; if (mem_cmd_address !== 32'h100) begin errors++; $display("[TB] FAIL fetch_addr got %h expected 00000100", mem_cmd_address); end
    checks++; if ({mem_cmd_wr, mem_cmd_mask} !== 5'b0_1111) begin errors++; $display("[TB] FAIL fetch_wrmask got %b expected 01111", {mem_cmd_wr, mem_cmd_mask}); end
    endCycle();
    idleInputs();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000013;
    @(negedge clock);
    checks++; if (ibus_rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL fetch_rsp got %b expected 1", ibus_rsp_ready); end
    checks++; if (ibus_rsp_inst !== 32'h00000013) begin errors++; $display("[TB] FAIL fetch_inst got %h expected 00000013", ibus_rsp_inst); end
    checks++; if (dbus_rsp_ready !== 1'b0) begin errors++; $display("[TB] FAIL fetch_drsp got %b expected 0", dbus_rsp_ready); end
    checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_release got %b expected 0", mem_cmd_valid); end
    endCycle();
    idleInputs();
    @(negedge clock);
    checks++; if ({ibus_rsp_ready, ibus_rsp_inst} !== 33'h0) begin errors++; $display("[TB] FAIL fetch_pulse got %b %h expected 0 0", ibus_rsp_ready, ibus_rsp_inst); end
    endCycle();
  endtask

  task automatic test_byte_store();
    idleInputs();
    dbus_cmd_valid = 1'b1; dbus_cmd_payload_wr = 1'b1; dbus_cmd_payload_address = 32'h203;
    dbus_cmd_payload_data = 32'hAB000000; dbus_cmd_payload_size = 2'd0;
    @(negedge clock);
    checks++; if (dbus_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL store_grant got %b expected 1", dbus_cmd_ready); end
    endCycle();
    idleInputs();
    mem_cmd_ready = 1'b1;
    @(negedge clock);
    checks++; if ({mem_cmd_valid, mem_cmd_wr} !== 2'b11) begin errors++; $display("[TB] FAIL store_vwr got %b expected 11", {mem_cmd_valid, mem_cmd_wr}); end
    checks++; if (mem_cmd_address !== 32'h200) begin errors++; $display("[TB] FAIL store_addr got %h expected 00000200", mem_cmd_address); end
    checks++; if (mem_cmd_mask !== 4'b1000) begin errors++; $display("[TB] FAIL store_mask got %b expected 1000", mem_cmd_mask); end
    checks++; if (mem_cmd_data !== 32'hAB000000) begin errors++; $display("[TB] FAIL store_data got %h expected ab000000", mem_cmd_data); end
    endCycle();
    idleInputs();
  endtask

  // Runs right after the store: a response now is unexpected only if the store pushed nothing
  task automatic test_unexpected();
    idleInputs();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
    @(negedge clock);
    checks++; if ({ibus_rsp_ready, dbus_rsp_ready} !== 2'b00) begin errors++; $display("[TB] FAIL unexp_route got %b expected 00", {ibus_rsp_ready, dbus_rsp_ready}); end
    endCycle();
    idleInputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (rsp_unexpected !== 1'b1) begin errors++; $display("[TB] FAIL unexp_sticky cycle %0d got %b expected 1", c, rsp_unexpected); end
      endCycle();
    end
  endtask

  task automatic test_starvation();
    string order;
    int    grants;
    logic  rspNext;
    order   = "";
    grants  = 0;
    rspNext = 1'b0;
    for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
      applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 2'd2, 1'b1, rspNext, 32'h0);
      @(negedge clock);
      if (dbus_cmd_ready === 1'b1) begin order = {order, "D"}; grants++; end
      else if (ibus_cmd_ready === 1'b1) begin order = {order, "I"}; grants++; end
      rspNext = mem_cmd_valid && !mem_cmd_wr;
      endCycle();
    end
    checks++; if (order != "DDDDIDDDDI") begin errors++; $display("[TB] FAIL starve_order got %s expected DDDDIDDDDI", order); end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, rspNext, 32'h0);
      @(negedge clock);
      rspNext = mem_cmd_valid && !mem_cmd_wr;
      endCycle();
    end
    idleInputs();
  endtask

  task automatic test_stall();
    idleInputs();
    dbus_cmd_valid = 1'b1; dbus_cmd_payload_address = 32'h40; dbus_cmd_payload_size = 2'd2;
    @(negedge clock);
    checks++; if (dbus_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_grant got %b expected 1", dbus_cmd_ready); end
    endCycle();
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h44, 32'h0, 2'd2, (c == 6), 1'b0, 32'h0);
      @(negedge clock);
      checks++; if ({mem_cmd_valid, mem_cmd_wr, mem_cmd_mask} !== 6'b10_1111) begin errors++; $display("[TB] FAIL stall_ctrl cycle %0d got %b expected 101111", c, {mem_cmd_valid, mem_cmd_wr, mem_cmd_mask}); end
      checks++; if (mem_cmd_address !== 32'h40) begin errors++; $display("[TB] FAIL stall_addr cycle %0d got %h expected 00000040", c, mem_cmd_address); end
      checks++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b00) begin errors++; $display("[TB] FAIL stall_noready cycle %0d got %b expected 00", c, {ibus_cmd_ready, dbus_cmd_ready}); end
      endCycle();
    end
    idleInputs();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
    @(negedge clock);
    checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_accept got %b expected 0", mem_cmd_valid); end
    checks++; if ({dbus_rsp_ready, ibus_rsp_ready} !== 2'b10 || dbus_rsp_data !== 32'h77) begin errors++; $display("[TB] FAIL stall_rsp got %b %h expected 10 00000077", {dbus_rsp_ready, ibus_rsp_ready}, dbus_rsp_data); end
    endCycle();
    idleInputs();
  endtask

  task automatic test_pending();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if (ibus_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL pend_igrant got %b expected 1", ibus_cmd_ready); end
    endCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if (dbus_cmd_ready !== 1'b0 || mem_cmd_address !== 32'h10) begin errors++; $display("[TB] FAIL pend_ihold got %b %h expected 0 00000010", dbus_cmd_ready, mem_cmd_address); end
    endCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if (dbus_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL pend_dgrant got %b expected 1", dbus_cmd_ready); end
    endCycle();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if (mem_cmd_address !== 32'h20) begin errors++; $display("[TB] FAIL pend_daddr got %h expected 00000020", mem_cmd_address); end
    endCycle();
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b1, 32'h24, 32'hCAFE, 2'd2, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b01) begin errors++; $display("[TB] FAIL pend_full got %b expected 01", {ibus_cmd_ready, dbus_cmd_ready}); end
    endCycle();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if ({mem_cmd_valid, mem_cmd_wr, ibus_cmd_ready} !== 3'b110) begin errors++; $display("[TB] FAIL pend_store got %b expected 110", {mem_cmd_valid, mem_cmd_wr, ibus_cmd_ready}); end
    endCycle();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h11);
    @(negedge clock);
    checks++; if (ibus_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL pend_withheld got %b expected 0", ibus_cmd_ready); end
    checks++; if ({ibus_rsp_ready, dbus_rsp_ready} !== 2'b10 || ibus_rsp_inst !== 32'h11) begin errors++; $display("[TB] FAIL pend_rsp1 got %b %h expected 10 00000011", {ibus_rsp_ready, dbus_rsp_ready}, ibus_rsp_inst); end
    endCycle();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h22);
    @(negedge clock);
    checks++; if (ibus_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL pend_third got %b expected 1", ibus_cmd_ready); end
    checks++; if ({ibus_rsp_ready, dbus_rsp_ready} !== 2'b01 || dbus_rsp_data !== 32'h22) begin errors++; $display("[TB] FAIL pend_rsp2 got %b %h expected 01 00000022", {ibus_rsp_ready, dbus_rsp_ready}, dbus_rsp_data); end
    endCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if (mem_cmd_address !== 32'h30) begin errors++; $display("[TB] FAIL pend_taddr got %h expected 00000030", mem_cmd_address); end
    endCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h33);
    @(negedge clock);
    checks++; if (ibus_rsp_ready !== 1'b1 || ibus_rsp_inst !== 32'h33) begin errors++; $display("[TB] FAIL pend_rsp3 got %b %h expected 1 00000033", ibus_rsp_ready, ibus_rsp_inst); end
    endCycle();
    idleInputs();
  endtask

  // Random traffic: requesters hold each request until granted, memory stalls and
  // answers at random; expectations come from a queue of outstanding sources.
  task automatic test_random();
    int          pend[$];
    bit          busy;
    int          busySrc;
    logic        expWr;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expMask;
    int          starve;
    bit          iReq;
    bit          dReq;
    logic [31:0] iPc;
    logic        dWr;
    logic [31:0] dAddr;
    logic [31:0] dData;
    logic [1:0]  dSize;
    bit          mr;
    bit          rv;
    logic [31:0] rdata;
    bit          room;
    bit          iElig;
    bit          dElig;
    bit          expIr;
    bit          expDr;
    bit          expIrsp;
    bit          expDrsp;
    bit          ivNow;
    busy = 0; busySrc = 0; starve = 0; iReq = 0; dReq = 0;
    expWr = 1'b0; expAddr = '0; expData = '0; expMask = '0;
    iPc = '0; dWr = 1'b0; dAddr = '0; dData = '0; dSize = '0;
    reset = 1'b1;
    idleInputs();
    endCycle();
    reset = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!iReq && $urandom_range(0, 99) < 60) begin iReq = 1; iPc = $urandom; end
      if (!dReq && $urandom_range(0, 99) < 60) begin
        dReq = 1; dWr = 1'($urandom_range(0, 1)); dAddr = $urandom; dData = $urandom; dSize = 2'($urandom_range(0, 3));
      end
      mr    = ($urandom_range(0, 99) < 60);
      rv    = (pend.size() > 0) && ($urandom_range(0, 99) < 50);
      rdata = $urandom;
      applyStimulus(iReq, iPc, dReq, dWr, dAddr, dData, dSize, mr, rv, rdata);
      ivNow = iReq;
      expIr = 0; expDr = 0;
      if (!busy) begin
        room  = pend.size() < DEPTH;
        iElig = iReq && room;
        dElig = dReq && (dWr || room);
        expIr = iElig && (starve == LIMIT || !dElig);
        expDr = dElig && !expIr;
      end
      expIrsp = rv && (pend.size() > 0) && (pend[0] == 0);
      expDrsp = rv && (pend.size() > 0) && (pend[0] == 1);
      @(negedge clock);
      checks++; if (ibus_cmd_ready !== expIr || dbus_cmd_ready !== expDr) begin errors++; $display("[TB] FAIL rand_grant cycle %0d got %b%b expected %b%b", cyc, ibus_cmd_ready, dbus_cmd_ready, expIr, expDr); end
      checks++; if (mem_cmd_valid !== busy) begin errors++; $display("[TB] FAIL rand_mvalid cycle %0d got %b expected %b", cyc, mem_cmd_valid, busy); end
      if (busy) begin
        checks++; if ({mem_cmd_wr, mem_cmd_address, mem_cmd_mask} !== {expWr, expAddr, expMask}) begin errors++; $display("[TB] FAIL rand_cmd cycle %0d got %b %h %b expected %b %h %b", cyc, mem_cmd_wr, mem_cmd_address, mem_cmd_mask, expWr, expAddr, expMask); end
        if (expWr) begin
          checks++; if (mem_cmd_data !== expData) begin errors++; $display("[TB] FAIL rand_data cycle %0d got %h expected %h", cyc, mem_cmd_data, expData); end
        end
      end
      checks++; if (ibus_rsp_ready !== expIrsp || ibus_rsp_inst !== (expIrsp ? rdata : 32'h0)) begin errors++; $display("[TB] FAIL rand_irsp cycle %0d got %b %h expected %b", cyc, ibus_rsp_ready, ibus_rsp_inst, expIrsp); end
      checks++; if (dbus_rsp_ready !== expDrsp || dbus_rsp_data !== (expDrsp ? rdata : 32'h0)) begin errors++; $display("[TB] FAIL rand_drsp cycle %0d got %b %h expected %b", cyc, dbus_rsp_ready, dbus_rsp_data, expDrsp); end
      checks++; if (rsp_unexpected !== 1'b0) begin errors++; $display("[TB] FAIL rand_unexp cycle %0d got %b expected 0", cyc, rsp_unexpected); end
      if (rv) void'(pend.pop_front());
      if (busy && mr) begin
        busy = 0;
        if (!expWr) pend.push_back(busySrc);
      end
      if (expIr) begin
        busy = 1; busySrc = 0; expWr = 1'b0; expAddr = iPc & ~32'h3; expMask = 4'hF; iReq = 0;
      end
      if (expDr) begin
        busy = 1; busySrc = 1; expWr = dWr; expAddr = dAddr & ~32'h3; expData = dData;
        expMask = expectedMask(dSize, dAddr); dReq = 0;
      end
      if (!ivNow || expIr) starve = 0;
      else if (expDr && starve < LIMIT) starve++;
      endCycle();
    end
    idleInputs();
  endtask

  // Scenario sequence; the second reset also proves the sticky error clears
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ifetch();
    test_byte_store();
    test_unexpected();
    test_reset();
    test_starvation();
    test_stall();
    test_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
